// File: rtl/fila_param_if.sv
// Request/response bundle for fila_param: producer-side requests plus
// occupancy flags and queue-ordered contents for display logic.
interface fila_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]            data_in;
    logic                        enqueue_in;
    logic                        dequeue_in;
    logic                        clr_err;
    logic [WIDTH-1:0]            data_out;
    logic [LW-1:0]               len_out;
    logic                        full;
    logic                        empty;
    logic                        almost_full;
    logic                        overflow;
    logic                        underflow;
    logic [DEPTH-1:0][WIDTH-1:0] vector;

    modport master (
        output data_in, enqueue_in, dequeue_in, clr_err,
        input  data_out, len_out, full, empty, almost_full,
        input  overflow, underflow, vector
    );

    modport slave (
        input  data_in, enqueue_in, dequeue_in, clr_err,
        output data_out, len_out, full, empty, almost_full,
        output overflow, underflow, vector
    );
endinterface

// File: rtl/fila_param.sv
// fila_param: circular-buffer FIFO of any depth >= 2 with level or
// rising-edge request qualification and sticky error flags.
module fila_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic        clk_10KHz,
    input  logic        reset,
    fila_param_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [LW-1:0] CNT_MAX  = LW'(DEPTH);
    localparam logic [LW-1:0] AF_TH    = LW'(AFULL_TH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW:0]   WRAP     = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [LW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             enq_q, deq_q;

    logic enq_go, deq_go;
    logic is_full, is_empty;
    logic do_enq, do_deq;
    logic ovf_set, unf_set;

    logic [DEPTH-1:0][WIDTH-1:0] vec_w;

    assign enq_go = EDGE_MODE ? (bus.enqueue_in & ~enq_q) : bus.enqueue_in;
    assign deq_go = EDGE_MODE ? (bus.dequeue_in & ~deq_q) : bus.dequeue_in;

    assign is_full  = (count_q == CNT_MAX);
    assign is_empty = (count_q == '0);

    // At full, a paired dequeue frees the head slot for the write.
    assign do_enq  = enq_go & (~is_full | deq_go);
    assign do_deq  = deq_go & ~is_empty;
    assign ovf_set = enq_go & is_full & ~deq_go;
    assign unf_set = deq_go & is_empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        data_d  = data_q;
        if (do_enq) begin
            tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
        end
        if (do_deq) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
            data_d = mem_q[head_q];
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
        unf_d = unf_set | (unf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            enq_q   <= 1'b0;
            deq_q   <= 1'b0;
        end else begin
            if (do_enq) begin
                mem_q[tail_q] <= bus.data_in;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            enq_q   <= bus.enqueue_in;
            deq_q   <= bus.dequeue_in;
        end
    end

    // Slot g of the view maps to head+g, folded back once past DEPTH.
    for (genvar g = 0; g < DEPTH; g++) begin : g_vec
        logic [PW:0]   raw;
        logic [PW-1:0] idx;
        assign raw = {1'b0, head_q} + (PW + 1)'(g);
        assign idx = (raw >= WRAP) ? PW'(raw - WRAP) : raw[PW-1:0];
        assign vec_w[g] = (LW'(g) < count_q) ? mem_q[idx] : '0;
    end

    assign bus.data_out    = data_q;
    assign bus.len_out     = count_q;
    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.almost_full = (count_q >= AF_TH);
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
    assign bus.vector      = vec_w;
endmodule

// File: tb/tb_fila_param.sv
// Directed bench for fila_param: 8x8 edge mode, 8x8 level mode and
// a 12-bit x 5 build, all sharing one clock and reset.
module tb_fila_param;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fila_param_if #(.WIDTH(8),  .DEPTH(8)) a ();
    fila_param_if #(.WIDTH(8),  .DEPTH(8)) m ();
    fila_param_if #(.WIDTH(12), .DEPTH(5)) c ();

    fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(1'b1)) u_a (
        .clk_10KHz(clk), .reset(rst), .bus(a)
    );
    fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(1'b0)) u_m (
        .clk_10KHz(clk), .reset(rst), .bus(m)
    );
    fila_param #(.WIDTH(12), .DEPTH(5), .EDGE_MODE(1'b1)) u_c (
        .clk_10KHz(clk), .reset(rst), .bus(c)
    );

    task automatic op_a(input logic e, input logic d, input logic [7:0] v);
        @(negedge clk);
        a.enqueue_in = e; a.dequeue_in = d; a.data_in = v;
        @(negedge clk);
        a.enqueue_in = 1'b0; a.dequeue_in = 1'b0;
    endtask

    task automatic op_c(input logic e, input logic d, input logic [11:0] v);
        @(negedge clk);
        c.enqueue_in = e; c.dequeue_in = d; c.data_in = v;
        @(negedge clk);
        c.enqueue_in = 1'b0; c.dequeue_in = 1'b0;
    endtask

    task automatic clr_a();
        @(negedge clk); a.clr_err = 1'b1;
        @(negedge clk); a.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        {a.data_in, a.enqueue_in, a.dequeue_in, a.clr_err} = '0;
        {m.data_in, m.enqueue_in, m.dequeue_in, m.clr_err} = '0;
        {c.data_in, c.enqueue_in, c.dequeue_in, c.clr_err} = '0;
        rst = 1'b1;
        #23;
        @(negedge clk); rst = 1'b0;
        checks++;
        if (a.len_out !== 4'd0 || a.empty !== 1'b1 || a.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_a_len got len=%0d e=%b f=%b exp len=0 e=1 f=0",
                     a.len_out, a.empty, a.full);
        end
        checks++;
        if (a.almost_full !== 1'b0 || a.overflow !== 1'b0 || a.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_a_flags got af=%b ov=%b un=%b exp 0 0 0",
                     a.almost_full, a.overflow, a.underflow);
        end
        checks++;
        if (a.data_out !== 8'h00 || a.vector !== '0) begin
            errors++;
            $display("FAIL reset_a_data got dout=%h vec=%h exp 0", a.data_out, a.vector);
        end
        checks++;
        if (c.len_out !== 3'd0 || c.empty !== 1'b1 || c.data_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_c got len=%0d e=%b dout=%h exp 0 1 000",
                     c.len_out, c.empty, c.data_out);
        end
    endtask

    task automatic test_fill();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 8'((i + 1) * 17);
            op_a(1'b1, 1'b0, v);
            checks++;
            if (a.len_out !== 4'(i + 1) || a.almost_full !== (i + 1 >= 6)) begin
                errors++;
                $display("FAIL fill_len[%0d] got len=%0d af=%b exp len=%0d af=%b",
                         i, a.len_out, a.almost_full, i + 1, (i + 1 >= 6));
            end
        end
        checks++;
        if (a.full !== 1'b1 || a.vector[0] !== 8'h11 || a.vector[7] !== 8'h88) begin
            errors++;
            $display("FAIL fill_full got f=%b v0=%h v7=%h exp 1 11 88",
                     a.full, a.vector[0], a.vector[7]);
        end
        op_a(1'b1, 1'b0, 8'h99);
        checks++;
        if (a.len_out !== 4'd8 || a.overflow !== 1'b1 || a.vector[7] !== 8'h88) begin
            errors++;
            $display("FAIL fill_overflow got len=%0d ov=%b v7=%h exp 8 1 88",
                     a.len_out, a.overflow, a.vector[7]);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            op_a(1'b0, 1'b1, 8'h00);
            checks++;
            if (a.data_out !== 8'((i + 1) * 17) || a.len_out !== 4'(7 - i)) begin
                errors++;
                $display("FAIL drain[%0d] got dout=%h len=%0d exp %h %0d",
                         i, a.data_out, a.len_out, 8'((i + 1) * 17), 7 - i);
            end
        end
        checks++;
        if (a.empty !== 1'b1 || a.underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got e=%b un=%b exp 1 0", a.empty, a.underflow);
        end
        op_a(1'b0, 1'b1, 8'h00);
        checks++;
        if (a.underflow !== 1'b1 || a.data_out !== 8'h88 || a.len_out !== 4'd0) begin
            errors++;
            $display("FAIL drain_underflow got un=%b dout=%h len=%0d exp 1 88 0",
                     a.underflow, a.data_out, a.len_out);
        end
        clr_a();
        checks++;
        if (a.underflow !== 1'b0 || a.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_err got ov=%b un=%b exp 0 0", a.overflow, a.underflow);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q [$];
        for (int i = 1; i <= 6; i++) op_a(1'b1, 1'b0, 8'(i));
        for (int i = 1; i <= 5; i++) op_a(1'b0, 1'b1, 8'h00);
        checks++;
        if (a.data_out !== 8'h05 || a.len_out !== 4'd1) begin
            errors++;
            $display("FAIL wrap_pre got dout=%h len=%0d exp 05 1", a.data_out, a.len_out);
        end
        for (int i = 0; i < 6; i++) op_a(1'b1, 1'b0, 8'(8'hA0 + i));
        checks++;
        if (a.len_out !== 4'd7 || a.vector[0] !== 8'h06 || a.vector[6] !== 8'hA5
            || a.vector[7] !== 8'h00) begin
            errors++;
            $display("FAIL wrap_vec got len=%0d v0=%h v6=%h v7=%h exp 7 06 a5 00",
                     a.len_out, a.vector[0], a.vector[6], a.vector[7]);
        end
        exp_q = '{8'h06, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 7; i++) begin
            op_a(1'b0, 1'b1, 8'h00);
            checks++;
            if (a.data_out !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_order[%0d] got %h exp %h", i, a.data_out, exp_q[i]);
            end
        end
    endtask

    task automatic test_simul();
        for (int i = 1; i <= 3; i++) op_a(1'b1, 1'b0, 8'(8'h30 + i));
        op_a(1'b1, 1'b1, 8'hC3);
        checks++;
        if (a.len_out !== 4'd3 || a.data_out !== 8'h31 || a.vector[0] !== 8'h32
            || a.vector[2] !== 8'hC3) begin
            errors++;
            $display("FAIL simul_mid got len=%0d dout=%h v0=%h v2=%h exp 3 31 32 c3",
                     a.len_out, a.data_out, a.vector[0], a.vector[2]);
        end
        for (int i = 0; i < 5; i++) op_a(1'b1, 1'b0, 8'(8'h40 + i));
        op_a(1'b1, 1'b1, 8'hEE);
        checks++;
        if (a.len_out !== 4'd8 || a.overflow !== 1'b0 || a.data_out !== 8'h32
            || a.vector[0] !== 8'h33 || a.vector[7] !== 8'hEE) begin
            errors++;
            $display("FAIL simul_full got len=%0d ov=%b dout=%h v0=%h v7=%h exp 8 0 32 33 ee",
                     a.len_out, a.overflow, a.data_out, a.vector[0], a.vector[7]);
        end
        for (int i = 0; i < 8; i++) op_a(1'b0, 1'b1, 8'h00);
        checks++;
        if (a.empty !== 1'b1 || a.data_out !== 8'hEE) begin
            errors++;
            $display("FAIL simul_drain got e=%b dout=%h exp 1 ee", a.empty, a.data_out);
        end
        op_a(1'b1, 1'b1, 8'h55);
        checks++;
        if (a.len_out !== 4'd1 || a.underflow !== 1'b1 || a.data_out !== 8'hEE
            || a.vector[0] !== 8'h55) begin
            errors++;
            $display("FAIL simul_empty got len=%0d un=%b dout=%h v0=%h exp 1 1 ee 55",
                     a.len_out, a.underflow, a.data_out, a.vector[0]);
        end
        clr_a();
        op_a(1'b0, 1'b1, 8'h00);
        checks++;
        if (a.data_out !== 8'h55 || a.empty !== 1'b1 || a.underflow !== 1'b0) begin
            errors++;
            $display("FAIL simul_tail got dout=%h e=%b un=%b exp 55 1 0",
                     a.data_out, a.empty, a.underflow);
        end
    endtask

    task automatic test_mode();
        @(negedge clk);
        a.enqueue_in = 1'b1; a.data_in = 8'h77;
        m.enqueue_in = 1'b1; m.data_in = 8'h77;
        repeat (4) @(negedge clk);
        a.enqueue_in = 1'b0; m.enqueue_in = 1'b0;
        checks++;
        if (a.len_out !== 4'd1) begin
            errors++;
            $display("FAIL mode_edge got len=%0d exp 1", a.len_out);
        end
        checks++;
        if (m.len_out !== 4'd4 || m.vector[3] !== 8'h77) begin
            errors++;
            $display("FAIL mode_level got len=%0d v3=%h exp 4 77", m.len_out, m.vector[3]);
        end
    endtask

    task automatic test_depth5();
        for (int i = 1; i <= 5; i++) begin
            op_c(1'b1, 1'b0, 12'(12'h100 + i));
            checks++;
            if (c.len_out !== 3'(i) || c.almost_full !== (i >= 3)) begin
                errors++;
                $display("FAIL d5_fill[%0d] got len=%0d af=%b exp %0d %b",
                         i, c.len_out, c.almost_full, i, (i >= 3));
            end
        end
        op_c(1'b1, 1'b0, 12'hFFF);
        checks++;
        if (c.full !== 1'b1 || c.overflow !== 1'b1 || c.vector[0] !== 12'h101
            || c.vector[4] !== 12'h105) begin
            errors++;
            $display("FAIL d5_overflow got f=%b ov=%b v0=%h v4=%h exp 1 1 101 105",
                     c.full, c.overflow, c.vector[0], c.vector[4]);
        end
        for (int i = 1; i <= 5; i++) begin
            op_c(1'b0, 1'b1, 12'h000);
            checks++;
            if (c.data_out !== 12'(12'h100 + i)) begin
                errors++;
                $display("FAIL d5_drain[%0d] got %h exp %h", i, c.data_out, 12'(12'h100 + i));
            end
        end
        op_c(1'b0, 1'b1, 12'h000);
        checks++;
        if (c.underflow !== 1'b1 || c.data_out !== 12'h105 || c.empty !== 1'b1) begin
            errors++;
            $display("FAIL d5_underflow got un=%b dout=%h e=%b exp 1 105 1",
                     c.underflow, c.data_out, c.empty);
        end
        @(negedge clk); c.clr_err = 1'b1;
        @(negedge clk); c.clr_err = 1'b0;
        checks++;
        if (c.underflow !== 1'b0 || c.overflow !== 1'b0) begin
            errors++;
            $display("FAIL d5_clr got ov=%b un=%b exp 0 0", c.overflow, c.underflow);
        end
        for (int i = 1; i <= 4; i++) op_c(1'b1, 1'b0, 12'(12'h200 + i));
        for (int i = 1; i <= 3; i++) op_c(1'b0, 1'b1, 12'h000);
        for (int i = 1; i <= 3; i++) op_c(1'b1, 1'b0, 12'(12'h300 + i));
        checks++;
        if (c.len_out !== 3'd4 || c.vector[0] !== 12'h204 || c.vector[3] !== 12'h303
            || c.vector[4] !== 12'h000) begin
            errors++;
            $display("FAIL d5_wrap got len=%0d v0=%h v3=%h v4=%h exp 4 204 303 000",
                     c.len_out, c.vector[0], c.vector[3], c.vector[4]);
        end
        op_c(1'b0, 1'b1, 12'h000);
        op_c(1'b0, 1'b1, 12'h000);
        checks++;
        if (c.data_out !== 12'h301) begin
            errors++;
            $display("FAIL d5_wrap_order got %h exp 301", c.data_out);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) op_a(1'b1, 1'b0, 8'(8'h60 + i));
        checks++;
        if (a.len_out !== 4'd5) begin
            errors++;
            $display("FAIL areset_pre got len=%0d exp 5", a.len_out);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        a.enqueue_in = 1'b1; a.data_in = 8'h5A;
        #1;
        checks++;
        if (a.len_out !== 4'd0 || a.empty !== 1'b1 || a.almost_full !== 1'b0
            || a.data_out !== 8'h00 || a.vector !== '0) begin
            errors++;
            $display("FAIL areset_now got len=%0d e=%b af=%b dout=%h vec=%h exp 0 1 0 00 0",
                     a.len_out, a.empty, a.almost_full, a.data_out, a.vector);
        end
        checks++;
        if (m.len_out !== 4'd0 || c.len_out !== 3'd0 || c.data_out !== 12'h000) begin
            errors++;
            $display("FAIL areset_others got mlen=%0d clen=%0d cdout=%h exp 0 0 000",
                     m.len_out, c.len_out, c.data_out);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        a.enqueue_in = 1'b0;
        checks++;
        if (a.len_out !== 4'd1 || a.vector[0] !== 8'h5A) begin
            errors++;
            $display("FAIL areset_held_req got len=%0d v0=%h exp 1 5a",
                     a.len_out, a.vector[0]);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_mode();
        test_depth5();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
